adder_seq_wide: RTL and testbench

ADDER_SEQ_WIDE -- requirements
Module: adder_seq_wide

---
 rtl/adder_seq_wide.sv | 160 ++++++++++++++++
 tb/tb_adder_seq_wide.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_wide.sv
// adder_seq_wide: byte-serial wide adder over one 8-bit carry-select slice, LSB first.
// Define ADDER_SEQ_SUB_EN to let inSub invert operand B for subtraction.

module adder_cs_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   // Upper nibble is computed for both possible carries; the low nibble carry selects.
   always_comb begin
      lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
      hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
      hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
      sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
      cout = lo[4] ? hi1[4] : hi0[4];
   end
endmodule

module adder_seq_wide #(
   parameter int unsigned WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inValid,
   output logic               inReady,
   input  logic [8*WORDS-1:0] inA,
   input  logic [8*WORDS-1:0] inB,
   input  logic               inCarry,
   input  logic               inSub,
   output logic               outValid,
   input  logic               outReady,
   output logic [8*WORDS-1:0] outSum,
   output logic               outCarry,
   output logic               outOverflow,
   output logic               outZero
);
   localparam int unsigned W    = 8 * WORDS;
   localparam int unsigned IdxW = $clog2(WORDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

`ifdef ADDER_SEQ_SUB_EN
   localparam logic SubEn = 1'b1;
`else
   localparam logic SubEn = 1'b0;
`endif

   logic [1:0]      state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    res_q, res_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic            have_q, have_d;

   logic [7:0] byte_a;
   logic [7:0] byte_b;
   logic [7:0] byte_s;
   logic       byte_c;

   assign byte_a = a_q[{idx_q, 3'b000} +: 8];
   assign byte_b = b_q[{idx_q, 3'b000} +: 8];

   adder_cs_8bit u_add (
      .a    (byte_a),
      .b    (byte_b),
      .cin  (carry_q),
      .sum  (byte_s),
      .cout (byte_c)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      have_d  = have_q;
      case (state_q)
         IDLE: begin
            if (inValid) begin
               a_d     = inA;
               b_d     = inB ^ {W{inSub & SubEn}};
               carry_d = inCarry;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[{idx_q, 3'b000} +: 8] = byte_s;
            carry_d = byte_c;
            idx_d   = idx_q + IdxW'(1);
            // Published outputs only change when a full result is ready.
            if (idx_q == IdxW'(WORDS - 1)) begin
               state_d = DONE;
               sum_d   = res_d;
               cout_d  = byte_c;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (byte_s[7] != a_q[W-1]);
               have_d  = 1'b1;
            end
         end
         DONE: begin
            if (outReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         have_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         have_q  <= have_d;
      end
   end

   assign inReady     = (state_q == IDLE);
   assign outValid    = (state_q == DONE);
   assign outSum      = sum_q;
   assign outCarry    = cout_q;
   assign outOverflow = ovf_q;
   // have_q keeps outZero at 0 until the first result exists.
   assign outZero     = have_q & ~|sum_q;

endmodule

// File: tb/tb_adder_seq_wide.sv
// Self-checking bench for adder_seq_wide: directed corner cases plus random transactions
// checked against an integer-arithmetic reference model.

module tb_adder_seq_wide;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [W-1:0] inA = '0;
   logic [W-1:0] inB = '0;
   logic         inCarry = 1'b0;
   logic         inSub = 1'b0;
   logic         outValid;
   logic         outReady = 1'b0;
   logic [W-1:0] outSum;
   logic         outCarry;
   logic         outOverflow;
   logic         outZero;

   int n_cmp = 0;
   int n_bad = 0;

   adder_seq_wide #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inValid     (inValid),
      .inReady     (inReady),
      .inA         (inA),
      .inB         (inB),
      .inCarry     (inCarry),
      .inSub       (inSub),
      .outValid    (outValid),
      .outReady    (outReady),
      .outSum      (outSum),
      .outCarry    (outCarry),
      .outOverflow (outOverflow),
      .outZero     (outZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full operand width.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] s, output logic co,
                                 output logic ov, output logic z);
      longint unsigned bev, tot;
      longint signed   sa, sb, r, lim;
      logic [W-1:0]    bw;
      logic            do_sub;
`ifdef ADDER_SEQ_SUB_EN
      do_sub = sub;
`else
      do_sub = 1'b0;
`endif
      bev = do_sub ? ((64'd1 << W) - 64'd1 - longint'(b)) : longint'(b);
      tot = longint'(a) + bev + longint'(cin);
      s   = tot[W-1:0];
      co  = tot[W];
      bw  = bev[W-1:0];
      sa  = longint'($signed(a));
      sb  = longint'($signed(bw));
      r   = sa + sb + longint'(cin);
      lim = 64'sd1 <<< (W - 1);
      ov  = (r >= lim) || (r < -lim);
      z   = (s == '0);
   endfunction

   task automatic check_outputs_clear(input string tag);
      chk({tag, ":in_ready"}, inReady, 1'b1);
      chk({tag, ":out_valid"}, outValid, 1'b0);
      chk({tag, ":out_sum"}, outSum, '0);
      chk({tag, ":out_carry"}, outCarry, 1'b0);
      chk({tag, ":out_ovf"}, outOverflow, 1'b0);
      chk({tag, ":out_zero"}, outZero, 1'b0);
   endtask

   // Called at a sample point (#1 after a rising edge) with the DUT idle.
   task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int hold, input bit first);
      logic [W-1:0] es;
      logic         ec, eo, ez;
      model(a, b, cin, sub, es, ec, eo, ez);
      chk({tag, ":ready_idle"}, inReady, 1'b1);
      inValid = 1'b1;
      inA = a;
      inB = b;
      inCarry = cin;
      inSub = sub;
      @(posedge clk); #1;
      for (int i = 1; i <= WORDS; i++) begin
         // Junk on the inputs while busy must not disturb the operation.
         inValid = 1'($urandom_range(0, 1));
         inA = $urandom;
         inB = $urandom;
         inCarry = 1'($urandom_range(0, 1));
         inSub = 1'($urandom_range(0, 1));
         chk({tag, ":ready_busy"}, inReady, 1'b0);
         if (first) chk({tag, ":sum_before_first"}, outSum, '0);
         @(posedge clk); #1;
         chk({tag, ":valid_latency"}, outValid, (i == WORDS));
      end
      for (int h = 0; h <= hold; h++) begin
         chk({tag, ":sum"}, outSum, es);
         chk({tag, ":carry"}, outCarry, ec);
         chk({tag, ":ovf"}, outOverflow, eo);
         chk({tag, ":zero"}, outZero, ez);
         chk({tag, ":valid_hold"}, outValid, 1'b1);
         chk({tag, ":ready_done"}, inReady, 1'b0);
         if (h < hold) begin
            inValid = (h == 1);
            outReady = 1'b0;
            @(posedge clk); #1;
         end
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      chk({tag, ":valid_drop"}, outValid, 1'b0);
      chk({tag, ":ready_back"}, inReady, 1'b1);
   endtask

   initial begin
      #3;
      check_outputs_clear("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_outputs_clear("reset_held");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_outputs_clear("after_release");

      run_txn("ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1);
      run_txn("wrap_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      run_txn("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      run_txn("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, 0, 1'b0);
      run_txn("backpressure", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3, 1'b0);

      // Abort in the second RUN cycle.
      inValid = 1'b1;
      inA = 32'hDEAD_BEEF;
      inB = 32'h0102_0304;
      inCarry = 1'b0;
      inSub = 1'b0;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_outputs_clear("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < WORDS + 2; i++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", outValid, 1'b0);
      end
      run_txn("after_abort", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1);

      for (int k = 0; k < 24; k++) begin
         run_txn("random", $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
